// File: rtl/csc_pkg.sv
// ---------------------------------------------------------------------------
// csc_pkg - definitions shared by the circulant-to-CSC row generator.
//
// Contents:
//   VAL_W   width of one real or imaginary part (signed)
//   NZ_MAX  number of nonzero slots in a first-row descriptor
//   idx_w() row/column index width for a given matrix order
//   cval_t  complex value {val_i, val_r}
//   state_t generator FSM states {IDLE, RUN}
// ---------------------------------------------------------------------------
package csc_pkg;

   localparam int VAL_W  = 32;
   localparam int NZ_MAX = 4;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic signed [VAL_W-1:0] val_i;
      logic signed [VAL_W-1:0] val_r;
   } cval_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/csc_slot_sel.sv
// ---------------------------------------------------------------------------
// csc_slot_sel - combinational walker over the active-slot mask.
//
// Ports:
//   mask       in  NZ_MAX  active-slot mask (bit k = slot k is emitted)
//   slot       in  2       current slot
//   next_slot  out 2       next active slot above 'slot', wrapping to the
//                          first active slot when none is left
//   first_slot out 2       lowest active slot (0 when the mask is empty)
//   is_last    out 1       no active slot above 'slot'
// ---------------------------------------------------------------------------
module csc_slot_sel
   import csc_pkg::*;
(
   input  logic [NZ_MAX-1:0] mask,
   input  logic [1:0]        slot,
   output logic [1:0]        next_slot,
   output logic [1:0]        first_slot,
   output logic              is_last
);

   always_comb begin
      first_slot = 2'd0;
      next_slot  = 2'd0;
      is_last    = 1'b1;
      // Descending scans so the lowest qualifying slot wins.
      for (int k = NZ_MAX - 1; k >= 0; k--) begin
         if (mask[k]) begin
            first_slot = 2'(k);
         end
      end
      for (int k = NZ_MAX - 1; k >= 0; k--) begin
         if (mask[k] && (k > int'(slot))) begin
            next_slot = 2'(k);
            is_last   = 1'b0;
         end
      end
      if (is_last) begin
         next_slot = first_slot;
      end
   end

endmodule

// File: rtl/csc_row_gen.sv
// ---------------------------------------------------------------------------
// csc_row_gen - expands one circulant first-row descriptor into the full
// list of (row, col, value) nonzeros, one entry per cycle. Row r is the
// first row rotated right by r columns; entries are emitted row by row in
// ascending slot order (columns may be unsorted within a row after wrap).
//
// Parameters:
//   MAT_RANK  matrix order N, power of 2 and >= 4
//   INDEX_W   derived index width (not overridable)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_val_i/_r  in     slot k value at [32k+:32], signed
//   load_col       in     slot k column at [INDEX_W*k+:INDEX_W]
//   load_nz4       in     1: slots 0..3 valid, 0: slots 0..1 valid
//   load_vld/_rdy         descriptor handshake
//   ent_vld/_rdy          entry handshake
//   ent_row, ent_col      entry coordinates
//   ent_val_i/_r          entry value
//   ent_last_row          last entry of the current row
//   ent_last              last entry of the matrix
//   busy                  generator is in RUN
//
// Build option:
//   CSC_GEN_ZERO_SKIP_EN  slots whose value is 0+0j are dropped at load;
//                         a descriptor with no active slot is accepted and
//                         produces no output.
// ---------------------------------------------------------------------------
module csc_row_gen
   import csc_pkg::*;
#(
   parameter  int MAT_RANK = 256,
   localparam int INDEX_W  = idx_w(MAT_RANK)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NZ_MAX*VAL_W-1:0]     load_val_i,
   input  logic [NZ_MAX*VAL_W-1:0]     load_val_r,
   input  logic [NZ_MAX*INDEX_W-1:0]   load_col,
   input  logic                        load_nz4,
   input  logic                        load_vld,
   output logic                        load_rdy,
   output logic                        ent_vld,
   input  logic                        ent_rdy,
   output logic [INDEX_W-1:0]          ent_row,
   output logic [INDEX_W-1:0]          ent_col,
   output logic [VAL_W-1:0]            ent_val_i,
   output logic [VAL_W-1:0]            ent_val_r,
   output logic                        ent_last_row,
   output logic                        ent_last,
   output logic                        busy
);

   state_t              state_p0, state_d;
   logic [INDEX_W-1:0]  row_p0;
   logic [1:0]          slot_p0;
   logic [NZ_MAX-1:0]   mask_p0;
   logic [INDEX_W-1:0]  col_p0 [NZ_MAX];
   cval_t               val_p0 [NZ_MAX];

   logic [NZ_MAX-1:0]   load_mask;
   logic [1:0]          ld_first, ld_next;
   logic                ld_last;
   logic                ld_unused;
   logic [1:0]          cur_first, cur_next;
   logic                cur_last;
   logic                load_fire, ent_fire;

   // Active-slot mask of the incoming descriptor.
   always_comb begin
      load_mask = load_nz4 ? 4'b1111 : 4'b0011;
`ifdef CSC_GEN_ZERO_SKIP_EN
      for (int k = 0; k < NZ_MAX; k++) begin
         if ((load_val_i[VAL_W*k +: VAL_W] == '0) &&
             (load_val_r[VAL_W*k +: VAL_W] == '0)) begin
            load_mask[k] = 1'b0;
         end
      end
`endif
   end

   // Only the first active slot of the incoming mask is needed at load.
   csc_slot_sel u_ld_sel (
      .mask       (load_mask),
      .slot       (2'd0),
      .next_slot  (ld_next),
      .first_slot (ld_first),
      .is_last    (ld_last)
   );
   assign ld_unused = ^{ld_next, ld_last};

   csc_slot_sel u_cur_sel (
      .mask       (mask_p0),
      .slot       (slot_p0),
      .next_slot  (cur_next),
      .first_slot (cur_first),
      .is_last    (cur_last)
   );

   // Control: ent_rdy only reaches registered state, never an output.
   always_comb begin
      state_d      = state_p0;
      load_rdy     = 1'b0;
      ent_vld      = 1'b0;
      busy         = 1'b0;
      ent_last_row = 1'b0;
      ent_last     = 1'b0;
      load_fire    = 1'b0;
      ent_fire     = 1'b0;
      case (state_p0)
         IDLE: begin
            load_rdy  = 1'b1;
            load_fire = load_vld;
            // An all-inactive descriptor is consumed without leaving IDLE.
            if (load_vld && (load_mask != '0)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            ent_vld      = 1'b1;
            busy         = 1'b1;
            ent_last_row = cur_last;
            ent_last     = cur_last && (row_p0 == INDEX_W'(MAT_RANK - 1));
            ent_fire     = ent_rdy;
            if (ent_rdy && ent_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0 <= IDLE;
      end else begin
         state_p0 <= state_d;
      end
   end

   // Stage p0: descriptor store and row/slot walk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_p0  <= '0;
         slot_p0 <= '0;
         mask_p0 <= '0;
         for (int k = 0; k < NZ_MAX; k++) begin
            col_p0[k] <= '0;
            val_p0[k] <= '0;
         end
      end else if (load_fire) begin
         row_p0  <= '0;
         slot_p0 <= ld_first;
         mask_p0 <= load_mask;
         for (int k = 0; k < NZ_MAX; k++) begin
            col_p0[k]       <= load_col[INDEX_W*k +: INDEX_W];
            val_p0[k].val_i <= load_val_i[VAL_W*k +: VAL_W];
            val_p0[k].val_r <= load_val_r[VAL_W*k +: VAL_W];
         end
      end else if (ent_fire) begin
         if (cur_last) begin
            slot_p0 <= cur_first;
            row_p0  <= row_p0 + INDEX_W'(1);
         end else begin
            slot_p0 <= cur_next;
         end
      end
   end

   // Natural INDEX_W-bit wrap gives the circulant column.
   assign ent_row   = row_p0;
   assign ent_col   = col_p0[slot_p0] + row_p0;
   assign ent_val_i = val_p0[slot_p0].val_i;
   assign ent_val_r = val_p0[slot_p0].val_r;

endmodule

// File: tb/tb_csc_row_gen.sv
// ---------------------------------------------------------------------------
// tb_csc_row_gen - directed and randomized checks of csc_row_gen at
// MAT_RANK=8 against a row-by-row expansion of the circulant first row.
// ---------------------------------------------------------------------------
module tb_csc_row_gen;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [127:0]  load_val_i = '0;
   logic [127:0]  load_val_r = '0;
   logic [11:0]   load_col = '0;
   logic          load_nz4 = 1'b0;
   logic          load_vld = 1'b0;
   logic          load_rdy;
   logic          ent_vld;
   logic          ent_rdy = 1'b0;
   logic [IW-1:0] ent_row, ent_col;
   logic [31:0]   ent_val_i, ent_val_r;
   logic          ent_last_row, ent_last, busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [71:0] exp_q[$];

   logic          alt_nz4;
   logic [11:0]   alt_cols;
   logic [127:0]  alt_vi, alt_vr;

   csc_row_gen #(.MAT_RANK(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_val_i   (load_val_i),
      .load_val_r   (load_val_r),
      .load_col     (load_col),
      .load_nz4     (load_nz4),
      .load_vld     (load_vld),
      .load_rdy     (load_rdy),
      .ent_vld      (ent_vld),
      .ent_rdy      (ent_rdy),
      .ent_row      (ent_row),
      .ent_col      (ent_col),
      .ent_val_i    (ent_val_i),
      .ent_val_r    (ent_val_r),
      .ent_last_row (ent_last_row),
      .ent_last     (ent_last),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [71:0] obs_entry();
      return {ent_row, ent_col, ent_val_i, ent_val_r, ent_last_row, ent_last};
   endfunction

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: every row is the first row rotated right by its row index.
   task automatic build(input bit nz4, input logic [11:0] cols,
                        input logic [127:0] vi, input logic [127:0] vr);
      int act[$];
      exp_q.delete();
      for (int k = 0; k < (nz4 ? 4 : 2); k++) begin
         bit on = 1'b1;
`ifdef CSC_GEN_ZERO_SKIP_EN
         if (vi[32*k +: 32] == 0 && vr[32*k +: 32] == 0) on = 1'b0;
`endif
         if (on) act.push_back(k);
      end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < act.size(); j++) begin
            int k = act[j];
            int c = (int'(cols[3*k +: 3]) + r) % N;
            bit lr = (j == act.size() - 1);
            exp_q.push_back({3'(r), 3'(c), vi[32*k +: 32], vr[32*k +: 32],
                             lr, lr && (r == N - 1)});
         end
      end
   endtask

   // Entered and left on a falling edge with the DUT in IDLE.
   task automatic run_matrix(input string tag, input bit nz4, input logic [11:0] cols,
                             input logic [127:0] vi, input logic [127:0] vr,
                             input int rdy_pct, input bit hold);
      int cyc = 0;
      build(nz4, cols, vi, vr);
      load_nz4 = nz4; load_col = cols; load_val_i = vi; load_val_r = vr;
      load_vld = 1'b1;
      chk({tag, " load_rdy_idle"}, 72'(load_rdy), 72'(1));
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         load_nz4 = alt_nz4; load_col = alt_cols; load_val_i = alt_vi; load_val_r = alt_vr;
      end else begin
         load_vld = 1'b0;
      end
      if (exp_q.size() == 0) begin
         chk({tag, " empty_vld"}, 72'(ent_vld), 72'(0));
         chk({tag, " empty_load_rdy"}, 72'(load_rdy), 72'(1));
         @(negedge clk);
         chk({tag, " empty_busy"}, 72'(busy), 72'(0));
         return;
      end
      while (exp_q.size() > 0 && cyc < 400) begin
         chk({tag, " ent_vld"}, 72'(ent_vld), 72'(1));
         chk({tag, " load_rdy_run"}, 72'(load_rdy), 72'(0));
         chk({tag, " busy"}, 72'(busy), 72'(1));
         chk({tag, " entry"}, obs_entry(), exp_q[0]);
         ent_rdy = ($urandom_range(99) < rdy_pct);
         if (ent_vld && ent_rdy) void'(exp_q.pop_front());
         @(negedge clk);
         cyc++;
      end
      chk({tag, " within_budget"}, 72'(exp_q.size()), 72'(0));
      ent_rdy = 1'b0;
      chk({tag, " done_vld"}, 72'(ent_vld), 72'(0));
      chk({tag, " done_load_rdy"}, 72'(load_rdy), 72'(1));
      chk({tag, " done_busy"}, 72'(busy), 72'(0));
   endtask

   logic [11:0]  c1, c2;
   logic [127:0] v1i, v1r, v2i, v2r, vz;

   initial begin
      int cyc;
      c1  = {3'd7, 3'd5, 3'd3, 3'd1};
      v1r = {32'd4, 32'd3, 32'd2, 32'd1};
      v1i = {-32'sd4, -32'sd3, -32'sd2, -32'sd1};
      c2  = {3'd3, 3'd4, 3'd6, 3'd2};
      v2r = {32'd77, 32'd66, 32'd6, 32'd5};
      v2i = {32'd70, 32'd60, -32'sd600, 32'd500};
      vz  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset load_rdy", 72'(load_rdy), 72'(1));
      chk("reset ent_vld", 72'(ent_vld), 72'(0));
      chk("reset busy", 72'(busy), 72'(0));
      chk("reset outputs", obs_entry(), 72'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Four slots, free-flowing consumer
      run_matrix("nz4", 1'b1, c1, v1i, v1r, 100, 1'b0);
      // Two slots, upper slots carry ignored data
      run_matrix("nz2", 1'b0, c2, v2i, v2r, 100, 1'b0);
      // Random backpressure on the first descriptor
      run_matrix("stall", 1'b1, c1, v1i, v1r, 50, 1'b0);

      // Reset in the middle of row 3
      load_nz4 = 1'b1; load_col = c1; load_val_i = v1i; load_val_r = v1r;
      load_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_vld = 1'b0;
      ent_rdy  = 1'b1;
      cyc = 0;
      while (ent_row != 3'd3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("midrun reached_row3", 72'(ent_row), 72'(3));
      rst_n = 1'b0;
      #1;
      chk("midrun ent_vld", 72'(ent_vld), 72'(0));
      chk("midrun load_rdy", 72'(load_rdy), 72'(1));
      chk("midrun busy", 72'(busy), 72'(0));
      chk("midrun outputs", obs_entry(), 72'(0));
      ent_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_matrix("restart", 1'b1, c1, v1i, v1r, 100, 1'b0);

      // load_vld held through RUN with a different descriptor
      alt_nz4 = 1'b0; alt_cols = c2; alt_vi = v2i; alt_vr = v2r;
      run_matrix("hold_first", 1'b1, c1, v1i, v1r, 80, 1'b1);
      run_matrix("hold_second", alt_nz4, alt_cols, alt_vi, alt_vr, 100, 1'b0);

      // Zero-valued slot and all-zero descriptor
      v2r = v1r; v2i = v1i;
      v2r[64 +: 32] = '0; v2i[64 +: 32] = '0;
      run_matrix("zero_slot2", 1'b1, c1, v2i, v2r, 100, 1'b0);
      run_matrix("all_zero", 1'b1, c1, vz, vz, 100, 1'b0);
      run_matrix("after_zero", 1'b0, c2, v1i, v1r, 100, 1'b0);

      // Randomized descriptors and backpressure
      for (int t = 0; t < 6; t++) begin
         logic [127:0] ri, rr;
         logic [11:0]  rc;
         rc = 12'($urandom);
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(3) == 0) begin
               ri[32*k +: 32] = '0; rr[32*k +: 32] = '0;
            end else begin
               ri[32*k +: 32] = $urandom; rr[32*k +: 32] = $urandom;
            end
         end
         run_matrix("random", 1'($urandom), rc, ri, rr, 30 + $urandom_range(70), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/csc_row_gen.md
Name: csc_row_gen

Overview:
- Downstream of the first-row nonzero store (csc_stor).
- Accepts one first-row descriptor for a circulant sparse matrix: up to 4 complex nonzeros, their column indices, and the nonzero count (2 or 4).
- Streams every nonzero entry of all MAT_RANK rows, one entry per cycle, over a valid/ready interface, in CSC-friendly (row, col, value) form.
- Row r is the first row cyclically shifted right by r columns.

Parameters:
- MAT_RANK, 256, matrix order N. Must be a power of 2 and at least 4.
- INDEX_W, $clog2(MAT_RANK), row/column index width. Local, not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_val_i  in  128  imag parts, slot k at [32k+:32], signed
- load_val_r  in  128  real parts, slot k at [32k+:32], signed
- load_col  in  4*INDEX_W  column of slot k at [INDEX_W*k+:INDEX_W]
- load_nz4  in  1  1 = 4 valid slots; 0 = 2 valid slots (0,1)
- load_vld  in  1  descriptor valid
- load_rdy  out  1  block can accept a descriptor
- ent_vld  out  1  entry valid
- ent_rdy  in  1  consumer accepts entry
- ent_row  out  INDEX_W  row index
- ent_col  out  INDEX_W  column index
- ent_val_i  out  32  imag value
- ent_val_r  out  32  real value
- ent_last_row  out  1  last entry of current row
- ent_last  out  1  last entry of matrix
- busy  out  1  RUN state

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE, all internal registers cleared.
  - load_rdy=1, ent_vld=0, busy=0.
  - ent_row, ent_col, ent_val_i, ent_val_r, ent_last_row and ent_last = 0.
  - Reset mid-run abandons the matrix with no further output.
- FSM states: IDLE, RUN.
- IDLE:
  - load_rdy=1.
  - On load_vld&&load_rdy, register all load_* inputs, set row=0, slot=first active slot, go to RUN.
  - First ent_vld is high the cycle after the load handshake (latency 1).
- RUN:
  - load_rdy=0; load_vld is ignored.
  - ent_vld=1.
  - Outputs come straight from registers: ent_row=row, ent_col=(col[slot]+row) mod MAT_RANK (natural INDEX_W-bit wrap), values = stored slot values.
  - On each ent_vld&&ent_rdy, advance to the next active slot. After the last active slot, slot returns to the first active slot and row increments.
- Slot order:
  - Ascending slot number 0..3 (0..1 when load_nz4=0).
  - No re-sorting after wrap; the consumer tolerates unsorted columns within a row.
- ent_last_row = 1 on the last active slot of each row.
- ent_last = ent_last_row && row==MAT_RANK-1.
- The handshake of the ent_last entry returns the FSM to IDLE. ent_vld drops the next cycle and load_rdy rises that same cycle. There are no back-to-back matrices without one IDLE cycle.
- Backpressure:
  - While ent_vld && !ent_rdy, all ent_* outputs hold stable.
  - ent_rdy has no combinational path to load_rdy or to ent_* outputs.
- Total handshakes per matrix = nz_count*MAT_RANK: 2N or 4N without the optional feature.
- Row counter is INDEX_W bits wide; ent_last detection prevents wrap past N-1.
- Slot count is 2 bits; the active-slot mask is 4 bits, derived at load.

Optional Feature:
- Macro: CSC_GEN_ZERO_SKIP_EN.
- Defined:
  - At load, a slot is inactive if it is beyond the count or its value is zero in both real and imag parts.
  - Inactive slots are never emitted; ent_last_row and ent_last mark the last active slot.
  - If no slot is active, the load is accepted and the block stays in IDLE with no output.
- Undefined:
  - Active slots are exactly the count-selected slots, zero values included.

Decomposition:
- Shared package csc_pkg:
  - VAL_W=32
  - NZ_MAX=4
  - function for index width
  - typedef for complex value struct {val_i, val_r}
  - state enum {IDLE, RUN}
- Sub-module csc_slot_sel: purely combinational.
  - Inputs: active mask and current slot.
  - Outputs: next active slot, first active slot, last-slot flag.
  - Reused by the mask logic and the row-advance logic.

Test Plan (MAT_RANK=8):
- Load nz4=1, cols {1,3,5,7}, values 1..4, ent_rdy=1.
  - Required: 32 entries.
  - Row 0 cols 1,3,5,7.
  - Row 1 cols 2,4,6,0 (wrap).
  - ent_last_row on every 4th entry.
  - ent_last on entry 32 at row 7, col 6.
  - load_rdy high the following cycle.
- Load nz4=0, cols {2,6}.
  - Required: 16 entries.
  - Row 7 cols 1,5.
  - ent_last_row on every 2nd entry.
- Random ent_rdy toggling during the first test's load.
  - Required: outputs stable while stalled.
  - Sequence identical to the first test.
  - load_rdy stays 0 throughout.
- Assert rst_n low mid-run at row 3.
  - Required: ent_vld=0 and load_rdy=1 immediately.
  - A new load restarts at row 0.
- load_vld held high during RUN with different data.
  - Required: ignored.
  - The next descriptor is accepted only after the IDLE return.
- With CSC_GEN_ZERO_SKIP_EN, nz4=1, slot 2 zero:
  - Required: 24 entries, slot 2 never emitted, ent_last_row on slot 3.
  - All four slots zero: no entries, and load_rdy remains 1.
